// File: rtl/calc_pkg.sv
// Shared opcodes, sequencer states and command layout for the calculator front-end.
package calc_pkg;

   typedef enum logic [3:0] {
      ADD = 4'b0000,
      SUB = 4'b0001,
      MUL = 4'b0010,
      DIV = 4'b0011,
      MOD = 4'b0100,
      AND = 4'b0101,
      OR  = 4'b0110,
      XOR = 4'b0111,
      SHL = 4'b1000,
      SHR = 4'b1001
   } calc_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      HOLD  = 2'd2
   } seq_state_e;

   localparam int CALC_NBITS = 4;

   typedef struct packed {
      logic [3:0]            op;
      logic [CALC_NBITS-1:0] a;
      logic [CALC_NBITS-1:0] b;
   } calc_cmd_t;

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == DIV) || (op == MOD);
   endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// Command FIFO; pointers carry one extra wrap bit so full and empty need no counter.
module calc_cmd_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
         if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/calc_sequencer.sv
// Sequencer between a command stream and the combinational Calculator ALU.
// Optional CALC_SEQ_DIV0_CHECK_EN forces a zeroed error response on div/mod by zero.
//   state | meaning
//   IDLE  | waiting for a queued command; pops it into the ALU input registers
//   DRIVE | ALU inputs held while the settle counter runs down
//   HOLD  | response offered, waiting for rsp_ready
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int NBITS         = 4,
   parameter int FIFO_DEPTH    = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [3:0]         cmd_op,
   input  logic [NBITS-1:0]   cmd_a,
   input  logic [NBITS-1:0]   cmd_b,
   output logic [3:0]         alu_op_select,
   output logic [NBITS-1:0]   alu_operand1,
   output logic [NBITS-1:0]   alu_operand2,
   input  logic [2*NBITS-1:0] alu_resultado,
   input  logic [3:0]         alu_banderas,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [3:0]         rsp_op,
   output logic [2*NBITS-1:0] rsp_result,
   output logic [3:0]         rsp_flags,
   output logic               rsp_error,
   output logic               busy,
   output logic [7:0]         op_count
);
   localparam int CMD_W = 4 + 2*NBITS;
   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_DRIVE = DRIVE;
   localparam logic [1:0] ST_HOLD  = HOLD;

   logic [1:0]       state;
   logic [CNT_W-1:0] settle_cnt;
   logic [CMD_W-1:0] head;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             div0;

   assign cmd_ready = ~full;
   assign push      = cmd_valid & cmd_ready;
   assign pop       = (state == ST_IDLE) & ~empty;
   assign busy      = (state != ST_IDLE) | ~empty;

`ifdef CALC_SEQ_DIV0_CHECK_EN
   assign div0 = is_div_op(alu_op_select) && (alu_operand2 == '0);
`else
   assign div0      = 1'b0;
   assign rsp_error = 1'b0;
`endif

   calc_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     ({cmd_op, cmd_a, cmd_b}),
      .head    (head),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         settle_cnt    <= '0;
         alu_op_select <= '0;
         alu_operand1  <= '0;
         alu_operand2  <= '0;
         rsp_valid     <= 1'b0;
         rsp_op        <= '0;
         rsp_result    <= '0;
         rsp_flags     <= '0;
         op_count      <= '0;
`ifdef CALC_SEQ_DIV0_CHECK_EN
         rsp_error     <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  {alu_op_select, alu_operand1, alu_operand2} <= head;
                  settle_cnt <= CNT_W'(SETTLE_CYCLES);
                  state      <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               // Terminal count: this edge takes the counter to zero, so capture now.
               if (settle_cnt == CNT_W'(1)) begin
                  settle_cnt <= '0;
                  rsp_valid  <= 1'b1;
                  rsp_op     <= alu_op_select;
                  rsp_result <= div0 ? '0 : alu_resultado;
                  rsp_flags  <= div0 ? '0 : alu_banderas;
`ifdef CALC_SEQ_DIV0_CHECK_EN
                  rsp_error  <= div0;
`endif
                  state      <= ST_HOLD;
               end else begin
                  settle_cnt <= settle_cnt - CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_count  <= op_count + 8'd1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer with a behavioural stand-in for the 4-bit Calculator ALU.
module tb_calc_sequencer;
   import calc_pkg::*;

   localparam int NBITS  = 4;
   localparam int SETTLE = 1;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [3:0]       cmd_op = '0;
   logic [NBITS-1:0] cmd_a = '0;
   logic [NBITS-1:0] cmd_b = '0;
   logic [3:0]       alu_op_select;
   logic [NBITS-1:0] alu_operand1;
   logic [NBITS-1:0] alu_operand2;
   logic [7:0]       alu_resultado;
   logic [3:0]       alu_banderas;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [3:0]       rsp_op;
   logic [7:0]       rsp_result;
   logic [3:0]       rsp_flags;
   logic             rsp_error;
   logic             busy;
   logic [7:0]       op_count;

   typedef struct {logic [3:0] op; logic [7:0] res; logic [3:0] flg; logic err;} rsp_t;
   typedef struct {logic [3:0] op; logic [7:0] res; logic [3:0] flg; logic err; int cyc;} rec_t;

   rec_t got_q[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   int   exp_ops = 0;

   calc_sequencer #(.NBITS(NBITS), .FIFO_DEPTH(4), .SETTLE_CYCLES(SETTLE)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_a         (cmd_a),
      .cmd_b         (cmd_b),
      .alu_op_select (alu_op_select),
      .alu_operand1  (alu_operand1),
      .alu_operand2  (alu_operand2),
      .alu_resultado (alu_resultado),
      .alu_banderas  (alu_banderas),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_op        (rsp_op),
      .rsp_result    (rsp_result),
      .rsp_flags     (rsp_flags),
      .rsp_error     (rsp_error),
      .busy          (busy),
      .op_count      (op_count)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Stand-in ALU: div/mod by zero yield visible garbage so forced responses are distinguishable.
   function automatic logic [7:0] alu_res(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         ADD:     return 8'(a) + 8'(b);
         SUB:     return 8'(a) - 8'(b);
         MUL:     return 8'(a) * 8'(b);
         DIV:     return (b == 0) ? 8'hFF : 8'(a / b);
         MOD:     return (b == 0) ? 8'h5A : 8'(a % b);
         AND:     return 8'(a & b);
         OR:      return 8'(a | b);
         XOR:     return 8'(a ^ b);
         SHL:     return 8'(a) << b;
         SHR:     return 8'(a >> b);
         default: return 8'hA5 ^ {a, b};
      endcase
   endfunction

   function automatic logic [3:0] alu_flg(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] r;
      r = alu_res(op, a, b);
      return {r == 8'h00, r[7], ^r, a > b};
   endfunction

   always_comb begin
      alu_resultado = alu_res(alu_op_select, alu_operand1, alu_operand2);
      alu_banderas  = alu_flg(alu_op_select, alu_operand1, alu_operand2);
   end

   function automatic rsp_t model_rsp(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      rsp_t m;
      m.op  = op;
      m.res = alu_res(op, a, b);
      m.flg = alu_flg(op, a, b);
      m.err = 1'b0;
`ifdef CALC_SEQ_DIV0_CHECK_EN
      if ((op == DIV || op == MOD) && b == 0) begin
         m.res = '0;
         m.flg = '0;
         m.err = 1'b1;
      end
`endif
      return m;
   endfunction

   // Each handshake is logged with the edge count at which the response became visible.
   always @(negedge clock) begin
      if (reset_n && rsp_valid && rsp_ready)
         got_q.push_back('{rsp_op, rsp_result, rsp_flags, rsp_error, cyc});
   end

   task automatic do_reset();
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      reset_n   = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      got_q.delete();
      exp_ops = 0;
   endtask

   task automatic push_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, output int edge_no);
      int n = 0;
      while (!cmd_ready && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      if (!cmd_ready) begin
         n_total++;
         $display("FAIL push_wait: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      end
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_a  = a;
      cmd_b  = b;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      edge_no = cyc;
   endtask

   task automatic wait_rsp(input int count, input int budget);
      int n = 0;
      while (got_q.size() < count && n < budget) begin
         @(posedge clock); #1;
         n++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
      n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (op_count !== 8'd0) $display("FAIL reset_op_count: got %0d want 0", op_count); else n_pass++;
      n_total++;
      if ({alu_op_select, alu_operand1, alu_operand2, rsp_op, rsp_result, rsp_flags, rsp_error} !== '0)
         $display("FAIL reset_datapath: got alu=%h/%h/%h rsp=%h/%h/%h/%b want all 0",
                  alu_op_select, alu_operand1, alu_operand2, rsp_op, rsp_result, rsp_flags, rsp_error);
      else n_pass++;
   endtask

   task automatic test_single_add();
      int e0;
      rsp_ready = 1'b1;
      push_cmd(ADD, 4'b0001, 4'b0001, e0);
      exp_ops++;
      wait_rsp(1, 20);
      n_total++; if (got_q.size() !== 1) $display("FAIL add_count: got %0d responses want 1", got_q.size()); else n_pass++;
      if (got_q.size() >= 1) begin
         n_total++; if (got_q[0].res !== 8'b0000_0010) $display("FAIL add_result: got %b want 00000010", got_q[0].res); else n_pass++;
         n_total++; if (got_q[0].cyc - e0 !== SETTLE + 1) $display("FAIL add_latency: got %0d want %0d", got_q[0].cyc - e0, SETTLE + 1); else n_pass++;
         n_total++; if (got_q[0].op !== 4'(ADD)) $display("FAIL add_op: got %h want 0", got_q[0].op); else n_pass++;
      end
      n_total++; if (op_count !== 8'd1) $display("FAIL add_op_count: got %0d want 1", op_count); else n_pass++;
      n_total++; if (alu_operand1 !== 4'b0001 || busy !== 1'b0)
         $display("FAIL add_idle_hold: got operand1=%b busy=%b want 0001 0", alu_operand1, busy); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int e0;
      int e1;
      rsp_t exp_q[$];
      got_q.delete();
      rsp_ready = 1'b1;
      push_cmd(MUL, 4'b1111, 4'b0011, e0);
      push_cmd(DIV, 4'b1110, 4'b0010, e1);
      for (int i = 0; i < 8; i++) begin
         logic [3:0] op, a, b;
         op = 4'($urandom_range(0, 15));
         a  = 4'($urandom);
         b  = 4'($urandom);
         exp_q.push_back(model_rsp(op, a, b));
         push_cmd(op, a, b, e1);
      end
      exp_ops += 10;
      wait_rsp(10, 80);
      n_total++; if (got_q.size() !== 10) $display("FAIL b2b_count: got %0d want 10", got_q.size()); else n_pass++;
      if (got_q.size() >= 2) begin
         n_total++; if (got_q[0].res !== 8'b0010_1101) $display("FAIL b2b_mul: got %b want 00101101", got_q[0].res); else n_pass++;
         n_total++; if (got_q[1].res !== 8'b0000_0111) $display("FAIL b2b_div: got %b want 00000111", got_q[1].res); else n_pass++;
         n_total++; if (got_q[1].cyc - got_q[0].cyc !== SETTLE + 2)
            $display("FAIL b2b_spacing: got %0d want %0d", got_q[1].cyc - got_q[0].cyc, SETTLE + 2); else n_pass++;
      end
      for (int i = 2; i < got_q.size() && i - 2 < exp_q.size(); i++) begin
         n_total++;
         if (got_q[i].op !== exp_q[i-2].op || got_q[i].res !== exp_q[i-2].res ||
             got_q[i].flg !== exp_q[i-2].flg || got_q[i].err !== exp_q[i-2].err ||
             got_q[i].cyc - got_q[i-1].cyc !== SETTLE + 2)
            $display("FAIL b2b_rand[%0d]: got op=%h res=%h flg=%h err=%b gap=%0d want op=%h res=%h flg=%h err=%b gap=%0d",
                     i, got_q[i].op, got_q[i].res, got_q[i].flg, got_q[i].err, got_q[i].cyc - got_q[i-1].cyc,
                     exp_q[i-2].op, exp_q[i-2].res, exp_q[i-2].flg, exp_q[i-2].err, SETTLE + 2);
         else n_pass++;
      end
      n_total++; if (op_count !== 8'(exp_ops)) $display("FAIL b2b_op_count: got %0d want %0d", op_count, exp_ops); else n_pass++;
   endtask

   task automatic test_backpressure();
      int e;
      logic [3:0] first_a;
      logic [7:0] held;
      rsp_t exp_q[$];
      got_q.delete();
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         logic [3:0] op, a, b;
         op = 4'($urandom_range(0, 15));
         a  = 4'($urandom);
         b  = 4'($urandom);
         if (i == 0) first_a = a;
         exp_q.push_back(model_rsp(op, a, b));
         push_cmd(op, a, b, e);
      end
      repeat (2) @(posedge clock); #1;
      held = rsp_result;
      n_total++; if (cmd_ready !== 1'b0) $display("FAIL bp_full: cmd_ready got %b want 0", cmd_ready); else n_pass++;
      n_total++; if (rsp_valid !== 1'b1 || busy !== 1'b1 || rsp_result !== exp_q[0].res || alu_operand1 !== first_a)
         $display("FAIL bp_hold: got valid=%b busy=%b res=%h a=%h want 1 1 %h %h", rsp_valid, busy, rsp_result, alu_operand1, exp_q[0].res, first_a);
      else n_pass++;
      cmd_valid = 1'b1;
      cmd_op = 4'($urandom);
      cmd_a  = 4'($urandom);
      cmd_b  = 4'($urandom);
      repeat (3) @(posedge clock); #1;
      cmd_valid = 1'b0;
      n_total++; if (cmd_ready !== 1'b0 || rsp_result !== held)
         $display("FAIL bp_sixth: got cmd_ready=%b res=%h want 0 %h", cmd_ready, rsp_result, held); else n_pass++;
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      n_total++; if (cmd_ready !== 1'b0) $display("FAIL bp_ready_pop_cycle: got %b want 0", cmd_ready); else n_pass++;
      @(posedge clock); #1;
      n_total++; if (cmd_ready !== 1'b1) $display("FAIL bp_ready_after_pop: got %b want 1", cmd_ready); else n_pass++;
      exp_ops += 5;
      wait_rsp(5, 60);
      repeat (4) @(posedge clock); #1;
      n_total++; if (got_q.size() !== 5) $display("FAIL bp_count: got %0d want 5", got_q.size()); else n_pass++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_total++;
         if (got_q[i].op !== exp_q[i].op || got_q[i].res !== exp_q[i].res ||
             got_q[i].flg !== exp_q[i].flg || got_q[i].err !== exp_q[i].err)
            $display("FAIL bp_rsp[%0d]: got op=%h res=%h flg=%h err=%b want op=%h res=%h flg=%h err=%b",
                     i, got_q[i].op, got_q[i].res, got_q[i].flg, got_q[i].err,
                     exp_q[i].op, exp_q[i].res, exp_q[i].flg, exp_q[i].err);
         else n_pass++;
      end
      n_total++; if (op_count !== 8'(exp_ops)) $display("FAIL bp_op_count: got %0d want %0d", op_count, exp_ops); else n_pass++;
   endtask

   task automatic test_div0();
      int e;
      rsp_t exp_q[$];
      logic exp_err;
      logic [7:0] exp_res;
`ifdef CALC_SEQ_DIV0_CHECK_EN
      exp_err = 1'b1;
      exp_res = 8'h00;
`else
      exp_err = 1'b0;
      exp_res = 8'hFF;
`endif
      got_q.delete();
      rsp_ready = 1'b1;
      push_cmd(DIV, 4'b0101, 4'b0000, e);
      for (int i = 0; i < 6; i++) begin
         logic [3:0] op, a, b;
         op = ($urandom_range(0, 1) == 0) ? 4'(DIV) : 4'(MOD);
         a  = 4'($urandom);
         b  = 4'($urandom_range(0, 2));
         exp_q.push_back(model_rsp(op, a, b));
         push_cmd(op, a, b, e);
      end
      exp_ops += 7;
      wait_rsp(7, 60);
      n_total++; if (got_q.size() !== 7) $display("FAIL div0_count: got %0d want 7", got_q.size()); else n_pass++;
      if (got_q.size() >= 1) begin
         n_total++; if (got_q[0].err !== exp_err || got_q[0].res !== exp_res)
            $display("FAIL div0_direct: got err=%b res=%h want err=%b res=%h", got_q[0].err, got_q[0].res, exp_err, exp_res);
         else n_pass++;
      end
      for (int i = 1; i < got_q.size() && i - 1 < exp_q.size(); i++) begin
         n_total++;
         if (got_q[i].res !== exp_q[i-1].res || got_q[i].flg !== exp_q[i-1].flg || got_q[i].err !== exp_q[i-1].err)
            $display("FAIL div0_rand[%0d]: got res=%h flg=%h err=%b want res=%h flg=%h err=%b",
                     i, got_q[i].res, got_q[i].flg, got_q[i].err, exp_q[i-1].res, exp_q[i-1].flg, exp_q[i-1].err);
         else n_pass++;
      end
   endtask

   task automatic test_reset_midflight();
      int e;
      rsp_ready = 1'b0;
      push_cmd(ADD, 4'd3, 4'd4, e);
      push_cmd(SUB, 4'd9, 4'd2, e);
      push_cmd(XOR, 4'd6, 4'd5, e);
      push_cmd(MUL, 4'd7, 4'd7, e);
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      n_total++; if (alu_operand1 !== 4'd9 || alu_op_select !== 4'(SUB) || rsp_valid !== 1'b0 || busy !== 1'b1)
         $display("FAIL mid_pre: got op=%h a=%h valid=%b busy=%b want 1 9 0 1", alu_op_select, alu_operand1, rsp_valid, busy);
      else n_pass++;
      reset_n = 1'b0;
      #1;
      n_total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'd0)
         $display("FAIL mid_reset_ctrl: got ready=%b valid=%b busy=%b count=%0d want 1 0 0 0", cmd_ready, rsp_valid, busy, op_count);
      else n_pass++;
      n_total++;
      if ({alu_op_select, alu_operand1, alu_operand2, rsp_op, rsp_result, rsp_flags, rsp_error} !== '0)
         $display("FAIL mid_reset_data: got alu=%h/%h/%h rsp=%h/%h/%h/%b want all 0",
                  alu_op_select, alu_operand1, alu_operand2, rsp_op, rsp_result, rsp_flags, rsp_error);
      else n_pass++;
      @(posedge clock); #1;
      reset_n = 1'b1;
      got_q.delete();
      exp_ops = 0;
      repeat (10) @(posedge clock); #1;
      n_total++; if (got_q.size() !== 0 || busy !== 1'b0 || op_count !== 8'd0 || cmd_ready !== 1'b1)
         $display("FAIL mid_after: got rsps=%0d busy=%b count=%0d ready=%b want 0 0 0 1", got_q.size(), busy, op_count, cmd_ready);
      else n_pass++;
   endtask

   task automatic test_wrap();
      int e;
      int bad = 0;
      rsp_t exp_q[$];
      got_q.delete();
      rsp_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         logic [3:0] a, b;
         a = 4'($urandom);
         b = 4'($urandom);
         exp_q.push_back(model_rsp(ADD, a, b));
         push_cmd(ADD, a, b, e);
      end
      exp_ops += 256;
      wait_rsp(256, 100);
      n_total++; if (got_q.size() !== 256) $display("FAIL wrap_count: got %0d want 256", got_q.size()); else n_pass++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i].res !== exp_q[i].res || got_q[i].flg !== exp_q[i].flg) bad++;
      n_total++; if (bad !== 0) $display("FAIL wrap_data: got %0d wrong results want 0", bad); else n_pass++;
      n_total++; if (op_count !== 8'(exp_ops)) $display("FAIL wrap_op_count: got %0d want %0d", op_count, 8'(exp_ops)); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL wrap_busy: got %b want 0", busy); else n_pass++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_add();
      test_back_to_back();
      test_backpressure();
      test_div0();
      test_reset_midflight();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
